// File: rtl/ahfp_float_to_int.sv
// ---------------------------------------------------------------------------
// ahfp_float_to_int
//   Two-stage pipelined converter from IEEE-754 single precision to a signed
//   two's-complement integer of OUT_W bits (OUT_W legal range 8..32). It sits
//   behind ahfp_floor, so its operands are normally already integral.
//   Stage 1 decodes the operand fields; stage 2 shifts, negates and saturates.
//   Out-of-range values and infinities saturate with overflow=1; NaN gives
//   result 0 with invalid=1. Valid/ready handshakes on both sides; the stage-2
//   register doubles as the output register.
//
//   Build option: define AHFP_F2I_RNE_EN to round to nearest-even in stage 2
//   instead of truncating toward zero. Latency is identical either way.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset, clears both stages
//   in_valid   in   data holds a valid operand
//   in_ready   out  operand accepted this cycle when in_valid is also high
//   data       in   single-precision operand
//   out_valid  out  result/overflow/invalid hold a valid conversion
//   out_ready  in   downstream takes the result this cycle
//   result     out  signed integer result
//   overflow   out  value saturated (out of range or +/-inf)
//   invalid    out  operand was NaN
// ---------------------------------------------------------------------------
module ahfp_float_to_int #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             overflow,
  output logic             invalid
);

  localparam logic signed [8:0] E_MAX   = 9'(OUT_W - 1);
  localparam logic [OUT_W-1:0]  SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]  SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};
  // Smallest magnitude a positive result cannot represent.
  localparam logic [31:0]       MAG_LIM = 32'd1 << (OUT_W - 1);

  // Stage 1 (decode)
  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q,  s1_sign_d;
  logic signed [8:0] s1_e_q,     s1_e_d;      // unbiased exponent
  logic [23:0]       s1_sig_q,   s1_sig_d;    // {1, mantissa}
  logic              s1_nan_q,   s1_nan_d;
  logic              s1_inf_q,   s1_inf_d;
  logic              s1_small_q, s1_small_d;  // |x| < 1 (includes zero/denormal)

  // Stage 2 (convert) / output register
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  result_q,    result_d;
  logic              overflow_q,  overflow_d;
  logic              invalid_q,   invalid_d;

  logic              s1_load;
  logic              s2_load;
  logic              zero_out;
  logic [31:0]       mag;
`ifdef AHFP_F2I_RNE_EN
  logic [55:0]       frac;       // [55:32] integer part, [31:0] bits shifted out
  logic              round_up;
`endif

  assign s2_load   = !out_valid_q || out_ready;
  assign s1_load   = !s1_valid_q || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign invalid   = invalid_q;

  // Stage 1: field decode
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_e_d     = s1_e_q;
    s1_sig_d   = s1_sig_q;
    s1_nan_d   = s1_nan_q;
    s1_inf_d   = s1_inf_q;
    s1_small_d = s1_small_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      s1_sign_d  = data[31];
      s1_e_d     = $signed({1'b0, data[30:23]}) - 9'sd127;
      s1_sig_d   = {1'b1, data[22:0]};
      s1_nan_d   = (&data[30:23]) && (|data[22:0]);
      s1_inf_d   = (&data[30:23]) && !(|data[22:0]);
      s1_small_d = data[30:23] < 8'd127;
    end
  end

  // With rounding, 0.5 <= |x| < 1 (e == -1) can round up to 1, so it is
  // kept out of the flush-to-zero path.
`ifdef AHFP_F2I_RNE_EN
  assign zero_out = s1_small_q && (s1_e_q != -9'sd1);
`else
  assign zero_out = s1_small_q;
`endif

  // Stage 2: shift, round, negate, saturate
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    invalid_d   = invalid_q;
    mag         = '0;
`ifdef AHFP_F2I_RNE_EN
    frac        = '0;
    round_up    = 1'b0;
`endif
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      result_d    = '0;
      overflow_d  = 1'b0;
      invalid_d   = 1'b0;
      if (s1_valid_q) begin
        if (s1_nan_q) begin
          invalid_d = 1'b1;
        end else if (s1_inf_q) begin
          result_d   = s1_sign_q ? SAT_NEG : SAT_POS;
          overflow_d = 1'b1;
        end else if (s1_e_q >= E_MAX) begin
          // -2^(OUT_W-1) is the one value at this exponent that still fits.
          result_d   = s1_sign_q ? SAT_NEG : SAT_POS;
          overflow_d = !(s1_sign_q && (s1_e_q == E_MAX) && (s1_sig_q[22:0] == 23'd0));
        end else if (!zero_out) begin
          if (s1_e_q >= 9'sd23) begin
            mag = {8'b0, s1_sig_q} << (s1_e_q - 9'sd23);
          end else begin
`ifdef AHFP_F2I_RNE_EN
            frac     = {s1_sig_q, 32'b0} >> (9'sd23 - s1_e_q);
            round_up = frac[31] && ((|frac[30:0]) || frac[32]);
            mag      = {8'b0, frac[55:32]} + {31'b0, round_up};
`else
            mag = {8'b0, s1_sig_q} >> (9'sd23 - s1_e_q);
`endif
          end
          // Only a rounding carry can push a positive magnitude to 2^(OUT_W-1).
          if (!s1_sign_q && (mag >= MAG_LIM)) begin
            result_d   = SAT_POS;
            overflow_d = 1'b1;
          end else begin
            result_d = s1_sign_q ? -mag[OUT_W-1:0] : mag[OUT_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_e_q      <= '0;
      s1_sig_q    <= '0;
      s1_nan_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_small_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_e_q      <= s1_e_d;
      s1_sig_q    <= s1_sig_d;
      s1_nan_q    <= s1_nan_d;
      s1_inf_q    <= s1_inf_d;
      s1_small_q  <= s1_small_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      invalid_q   <= invalid_d;
    end
  end

endmodule

// File: tb/tb_ahfp_float_to_int.sv
// ---------------------------------------------------------------------------
// tb_ahfp_float_to_int
//   Self-checking bench for ahfp_float_to_int (OUT_W = 32). Expected results
//   come from a value-level model: the float is treated as sig * 2^(e-23),
//   truncated (or rounded to nearest-even when AHFP_F2I_RNE_EN is defined)
//   and range-checked against the signed OUT_W-bit range.
// ---------------------------------------------------------------------------
module tb_ahfp_float_to_int;

  localparam int OUT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] result;
  logic             overflow;
  logic             invalid;

  ahfp_float_to_int #(.OUT_W(OUT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      d;
    logic [OUT_W-1:0] r;
    logic             o;
    logic             i;
  } exp_t;

  exp_t exp_q[$];

  int vec_count = 0;
  int err_count = 0;

  // Values sampled just before the next active edge.
  logic             s_in_ready;
  logic             s_out_valid;
  logic [OUT_W-1:0] s_result;
  logic             s_ovf;
  logic             s_inv;

  // Value-level reference model.
  function automatic exp_t model(input logic [31:0] f);
    exp_t   x;
    longint e, sig, q, v, vmax, vmin;
`ifdef AHFP_F2I_RNE_EN
    longint num, rem;
`endif
    x.d  = f;
    x.r  = '0;
    x.o  = 1'b0;
    x.i  = 1'b0;
    vmax = (longint'(1) << (OUT_W - 1)) - 1;
    vmin = -(longint'(1) << (OUT_W - 1));
    q    = 0;
    if (f[30:23] == 8'hFF) begin
      if (f[22:0] != 23'd0) begin
        x.i = 1'b1;
        return x;
      end
      q = vmax + 2;                       // infinite magnitude
    end else if (f[30:23] != 8'h00) begin
      e   = longint'({56'b0, f[30:23]}) - 127;
      sig = longint'({40'b0, 1'b1, f[22:0]});
      if (e >= 32) begin
        q = vmax + 2;                     // far beyond any OUT_W range
      end else begin
`ifdef AHFP_F2I_RNE_EN
        if (e < -1) q = 0;                // |x| < 0.5
        else begin
          num = sig << (e + 1);           // value * 2^24
          q   = num >> 24;
          rem = num & 64'h00FF_FFFF;
          if (rem > 64'h0080_0000 || (rem == 64'h0080_0000 && q[0])) q = q + 1;
        end
`else
        if (e < 0) q = 0;
        else q = (sig << e) >> 23;
`endif
      end
    end
    v = f[31] ? -q : q;
    if (v > vmax) begin
      x.r = vmax[OUT_W-1:0];
      x.o = 1'b1;
    end else if (v < vmin) begin
      x.r = vmin[OUT_W-1:0];
      x.o = 1'b1;
    end else begin
      x.r = v[OUT_W-1:0];
    end
    return x;
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [31:0] f;
    f = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: f[30:23] = 8'($urandom_range(110, 162));
      5:             ;                                          // fully random
      6:             f[30:0] = {8'hFF, 23'd0};                  // +/-inf
      7:             f[30:23] = 8'hFF;                          // NaN (mant forced)
      8:             f[30:23] = 8'h00;                          // zero/denormal
      default: begin
        f[30:23] = 8'($urandom_range(156, 158));                // e = 29..31
        if ($urandom_range(0, 1) == 0) f[22:0] = 23'd0;
      end
    endcase
    if (f[30:23] == 8'hFF && f[22:0] == 23'd0 && $urandom_range(0, 1) == 0) f[0] = 1'b1;
    return f;
  endfunction

  // Drive one cycle's inputs, sample outputs before the edge, step past it.
  task automatic drive_cycle(input logic iv, input logic [31:0] d, input logic rdy);
    in_valid  = iv;
    data      = d;
    out_ready = rdy;
    #2;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_result    = result;
    s_ovf       = overflow;
    s_inv       = invalid;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data      = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    drive_cycle(1'b0, 32'h0, 1'b0);
    vec_count++;
    if (s_out_valid !== 1'b0) begin err_count++; $display("FAIL reset_out_valid got=%b want=0", s_out_valid); end
    vec_count++;
    if (s_in_ready !== 1'b1) begin err_count++; $display("FAIL reset_in_ready got=%b want=1", s_in_ready); end
    vec_count++;
    if ({s_result, s_ovf, s_inv} !== {32'h0, 2'b00}) begin
      err_count++;
      $display("FAIL reset_outputs got result=%h ovf=%b inv=%b want 0/0/0", s_result, s_ovf, s_inv);
    end
    $display("reset: out_valid=%b in_ready=%b result=%h", s_out_valid, s_in_ready, s_result);
  endtask

  // Spec vectors with constant expectations; also checks 2-cycle latency.
  task automatic test_vectors();
    logic [31:0] vd [11];
    logic [31:0] vr [11];
    logic [1:0]  vf [11];   // {overflow, invalid}
    vd = '{32'h4000_0000, 32'h4555_F000, 32'hC2FE_0000, 32'h5306_BBF0, 32'hCF00_0000,
           32'h7FC0_0000, 32'h3F0F_5C29, 32'h3FC0_0000, 32'h4020_0000, 32'h3F40_0000,
           32'hFF80_0000};
`ifdef AHFP_F2I_RNE_EN
    vr = '{32'h2, 32'hD5F, 32'hFFFF_FF81, 32'h7FFF_FFFF, 32'h8000_0000,
           32'h0, 32'h1, 32'h2, 32'h2, 32'h1, 32'h8000_0000};
`else
    vr = '{32'h2, 32'hD5F, 32'hFFFF_FF81, 32'h7FFF_FFFF, 32'h8000_0000,
           32'h0, 32'h0, 32'h1, 32'h2, 32'h0, 32'h8000_0000};
`endif
    vf = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    for (int k = 0; k < 11; k++) begin
      drive_cycle(1'b1, vd[k], 1'b1);
      drive_cycle(1'b0, 32'h0, 1'b1);
      vec_count++;
      if (s_out_valid !== 1'b0) begin
        err_count++;
        $display("FAIL vec_early data=%h out_valid got=%b want=0", vd[k], s_out_valid);
      end
      drive_cycle(1'b0, 32'h0, 1'b1);
      vec_count++;
      if (s_out_valid !== 1'b1 || s_result !== vr[k] || {s_ovf, s_inv} !== vf[k]) begin
        err_count++;
        $display("FAIL vec data=%h got v=%b r=%h o=%b i=%b want v=1 r=%h o=%b i=%b",
                 vd[k], s_out_valid, s_result, s_ovf, s_inv, vr[k], vf[k][1], vf[k][0]);
      end
      $display("vec: data=%h result=%h ovf=%b inv=%b", vd[k], s_result, s_ovf, s_inv);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] vals [4];
    int   acc = 0;
    int   emitted = 0;
    int   idx;
    logic rdy;
    exp_t e;
    vals = '{32'h4555_F000, 32'hC2FE_0000, 32'h4000_0000, 32'h5306_BBF0};
    for (int c = 0; c < 40; c++) begin
      rdy = (c >= 5);
      idx = (acc < 4) ? acc : 0;
      drive_cycle(acc < 4, vals[idx], rdy);
      if (c >= 2 && c < 5) begin
        vec_count++;
        if (s_in_ready !== 1'b0 || s_out_valid !== 1'b1 || s_result !== exp_q[0].r) begin
          err_count++;
          $display("FAIL bp_stall cyc=%0d in_ready=%b out_valid=%b result=%h want 0/1/%h",
                   c, s_in_ready, s_out_valid, s_result, exp_q[0].r);
        end
      end
      if (s_out_valid && rdy) begin
        vec_count++;
        if (exp_q.size() == 0) begin
          err_count++;
          $display("FAIL bp_extra result=%h with no pending input", s_result);
        end else begin
          e = exp_q.pop_front();
          emitted++;
          if ({s_result, s_ovf, s_inv} !== {e.r, e.o, e.i}) begin
            err_count++;
            $display("FAIL bp_out data=%h got r=%h o=%b i=%b want r=%h o=%b i=%b",
                     e.d, s_result, s_ovf, s_inv, e.r, e.o, e.i);
          end
          $display("bp: data=%h result=%h ovf=%b inv=%b", e.d, s_result, s_ovf, s_inv);
        end
      end
      if (acc < 4 && s_in_ready) begin
        exp_q.push_back(model(vals[acc]));
        acc++;
      end
      if (acc == 4 && emitted == 4) break;
    end
    vec_count++;
    if (acc != 4 || emitted != 4) begin
      err_count++;
      $display("FAIL bp_count accepted=%0d emitted=%0d want 4/4", acc, emitted);
    end
    exp_q.delete();
  endtask

  task automatic test_random(input int n);
    int          sent = 0;
    logic        iv, rdy;
    logic [31:0] d;
    exp_t        e;
    d = gen_operand();
    for (int c = 0; c < 8 * n + 200; c++) begin
      iv  = (sent < n) && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      drive_cycle(iv, d, rdy);
      if (s_out_valid && rdy) begin
        vec_count++;
        if (exp_q.size() == 0) begin
          err_count++;
          $display("FAIL rnd_extra result=%h with no pending input", s_result);
        end else begin
          e = exp_q.pop_front();
          if ({s_result, s_ovf, s_inv} !== {e.r, e.o, e.i}) begin
            err_count++;
            $display("FAIL rnd_out data=%h got r=%h o=%b i=%b want r=%h o=%b i=%b",
                     e.d, s_result, s_ovf, s_inv, e.r, e.o, e.i);
          end
          $display("rnd: data=%h result=%h ovf=%b inv=%b", e.d, s_result, s_ovf, s_inv);
        end
      end
      if (iv && s_in_ready) begin
        exp_q.push_back(model(d));
        sent++;
        d = gen_operand();
      end
      if (sent == n && exp_q.size() == 0) break;
    end
    vec_count++;
    if (sent != n || exp_q.size() != 0) begin
      err_count++;
      $display("FAIL rnd_drain sent=%0d pending=%0d want %0d/0", sent, exp_q.size(), n);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 32'h4555_F000, 1'b0);
    drive_cycle(1'b1, 32'hCF00_0000, 1'b0);
    reset = 1'b1;
    drive_cycle(1'b0, 32'h0, 1'b0);
    vec_count++;
    if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0) begin
      err_count++;
      $display("FAIL rst_mid_full out_valid=%b in_ready=%b want 1/0", s_out_valid, s_in_ready);
    end
    reset = 1'b0;
    drive_cycle(1'b0, 32'h0, 1'b1);
    vec_count++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || {s_result, s_ovf, s_inv} !== {32'h0, 2'b00}) begin
      err_count++;
      $display("FAIL rst_mid_clear out_valid=%b in_ready=%b r=%h o=%b i=%b want 0/1/0/0/0",
               s_out_valid, s_in_ready, s_result, s_ovf, s_inv);
    end
    drive_cycle(1'b0, 32'h0, 1'b1);
    vec_count++;
    if (s_out_valid !== 1'b0) begin
      err_count++;
      $display("FAIL rst_mid_s1 out_valid=%b want 0 (stage 1 not discarded)", s_out_valid);
    end
    $display("reset_mid: out_valid=%b in_ready=%b result=%h", s_out_valid, s_in_ready, s_result);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_pressure();
    test_random(300);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
